// File: rtl/horner_pkg.sv
// Shared definitions for the Horner evaluator scheduler.
// Holds the FSM state encoding, default sizing, and a helper that gives the
// request-to-result latency for a given degree and multiplier depth.
package horner_pkg;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_DEG_W   = 4;
    localparam int DEF_MAX_DEG = 15;
    localparam int DEF_MUL_LAT = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MUL,
        ST_MWAIT,
        ST_ADD,
        ST_DONE
    } state_t;

    // Cycles from the accept cycle (cycle 0) to the first result_valid cycle.
    function automatic int total_latency(input int n, input int mul_lat);
        return 2 + n * (mul_lat + 1);
    endfunction

endpackage

// File: rtl/horner_mul_pipe.sv
// Registered multiplier with LAT pipeline stages and a matching valid chain.
// Ports:
//   clk, rst        clock, synchronous active-high clear of all stages
//   in_valid, a, b  operands issued this cycle
//   out_valid, prod product of the operands issued LAT cycles earlier
// PROD_W selects how many product bits are kept (WIDTH or 2*WIDTH).
module horner_mul_pipe #(
    parameter int WIDTH  = 32,
    parameter int PROD_W = 64,
    parameter int LAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic              out_valid,
    output logic [PROD_W-1:0] prod
);

    logic [PROD_W-1:0] stage_q [LAT];
    logic [PROD_W-1:0] stage_d [LAT];
    logic [LAT-1:0]    vld_q;
    logic [LAT-1:0]    vld_d;

    always_comb begin
        // Operands are widened first so the multiply is carried out at PROD_W bits.
        stage_d[0] = PROD_W'(a) * PROD_W'(b);
        vld_d[0]   = in_valid;
        for (int i = 1; i < LAT; i++) begin
            stage_d[i] = stage_q[i-1];
            vld_d[i]   = vld_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            vld_q   <= vld_d;
            stage_q <= stage_d;
        end
    end

    assign prod      = stage_q[LAT-1];
    assign out_valid = vld_q[LAT-1];

endmodule

// File: rtl/horner_sched.sv
// Sequencing controller for the Horner polynomial evaluator.
// Accepts (x, degree), reads coefficients c[N]..c[0] from a synchronous
// memory, iterates acc = acc*x + c[i] through a pipelined multiplier and
// returns the result over a valid/ready handshake.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   start_valid/start_ready       request handshake, x_in and degree qualify it
//   coef_rd_en/coef_addr          memory read strobe/index, data returns next cycle on coef_data
//   result_valid/result_ready     result handshake, result holds the value
//   ovf                           sticky overflow, only when HORNER_OVF_EN is defined
// State table:
//   IDLE  | waiting for a request, read of c[N] issued on accept
//   LOAD  | acc takes c[N]
//   MUL   | acc*x issued to multiplier, read of c[idx-1] issued
//   MWAIT | waiting for the multiplier pipeline
//   ADD   | acc = product + c[idx-1]
//   DONE  | result presented until consumed
module horner_sched
    import horner_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int MAX_DEG = DEF_MAX_DEG,
    parameter int DEG_W   = DEF_DEG_W,
    parameter int MUL_LAT = DEF_MUL_LAT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] x_in,
    input  logic [DEG_W-1:0] degree,
    output logic             coef_rd_en,
    output logic [DEG_W-1:0] coef_addr,
    input  logic [WIDTH-1:0] coef_data,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] result
`ifdef HORNER_OVF_EN
    ,
    output logic             ovf
`endif
);

`ifdef HORNER_OVF_EN
    localparam int PROD_W = 2 * WIDTH;
`else
    localparam int PROD_W = WIDTH;
`endif
    localparam int CNT_W = (MUL_LAT > 2) ? $clog2(MUL_LAT - 1) : 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [DEG_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] coef_reg_q, coef_reg_d;
    logic             rd_q, rd_d;
    logic             start_ready_q, start_ready_d;
    logic             result_valid_q, result_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
`ifdef HORNER_OVF_EN
    logic             ovf_q, ovf_d;
    logic [WIDTH:0]   sum_ext;
`endif

    logic [PROD_W-1:0] prod;
    logic              mul_vld;
    logic [DEG_W-1:0]  deg_c;
    logic [WIDTH-1:0]  addend;
    logic [WIDTH-1:0]  sum;
    logic              step_ovf;

    horner_mul_pipe #(
        .WIDTH  (WIDTH),
        .PROD_W (PROD_W),
        .LAT    (MUL_LAT)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (state_q == ST_MUL),
        .a         (acc_q),
        .b         (x_q),
        .out_valid (mul_vld),
        .prod      (prod)
    );

    assign deg_c = (int'(degree) > MAX_DEG) ? DEG_W'(MAX_DEG) : degree;

    // With a one-stage multiplier ADD lands in the cycle the coefficient
    // read returns, so the memory output is used directly; otherwise the
    // captured copy is used.
    assign addend = rd_q ? coef_data : coef_reg_q;

`ifdef HORNER_OVF_EN
    assign sum_ext  = {1'b0, prod[WIDTH-1:0]} + {1'b0, addend};
    assign sum      = sum_ext[WIDTH-1:0];
    assign step_ovf = sum_ext[WIDTH] | (|prod[PROD_W-1:WIDTH]);
`else
    assign sum      = prod + addend;
    assign step_ovf = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        x_d            = x_q;
        acc_d          = acc_q;
        idx_d          = idx_q;
        cnt_d          = cnt_q;
        coef_reg_d     = coef_reg_q;
        rd_d           = 1'b0;
        result_d       = result_q;
        coef_rd_en     = 1'b0;
        coef_addr      = '0;
`ifdef HORNER_OVF_EN
        ovf_d          = ovf_q;
`endif

        if (rd_q) begin
            coef_reg_d = coef_data;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_valid) begin
                    x_d        = x_in;
                    idx_d      = deg_c;
                    coef_rd_en = 1'b1;
                    coef_addr  = deg_c;
`ifdef HORNER_OVF_EN
                    ovf_d      = 1'b0;
`endif
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                acc_d = coef_data;
                if (idx_q == '0) begin
                    result_d = coef_data;
                    state_d  = ST_DONE;
                end else begin
                    state_d = ST_MUL;
                end
            end
            ST_MUL: begin
                coef_rd_en = 1'b1;
                coef_addr  = idx_q - DEG_W'(1);
                rd_d       = 1'b1;
                if (MUL_LAT == 1) begin
                    state_d = ST_ADD;
                end else begin
                    cnt_d   = CNT_W'(MUL_LAT - 2);
                    state_d = ST_MWAIT;
                end
            end
            ST_MWAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_ADD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_ADD: begin
                idx_d = idx_q - DEG_W'(1);
                if (mul_vld) begin
                    acc_d = sum;
`ifdef HORNER_OVF_EN
                    ovf_d = ovf_q | step_ovf;
`endif
                end
                if (idx_q == DEG_W'(1)) begin
                    result_d = sum;
                    state_d  = ST_DONE;
                end else begin
                    state_d = ST_MUL;
                end
            end
            ST_DONE: begin
                if (result_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The read strobe is combinational from state; hold it off during reset.
        if (rst) begin
            coef_rd_en = 1'b0;
            coef_addr  = '0;
        end

        start_ready_d  = (state_d == ST_IDLE);
        result_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            x_q            <= '0;
            acc_q          <= '0;
            idx_q          <= '0;
            cnt_q          <= '0;
            coef_reg_q     <= '0;
            rd_q           <= 1'b0;
            start_ready_q  <= 1'b1;
            result_valid_q <= 1'b0;
            result_q       <= '0;
`ifdef HORNER_OVF_EN
            ovf_q          <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            x_q            <= x_d;
            acc_q          <= acc_d;
            idx_q          <= idx_d;
            cnt_q          <= cnt_d;
            coef_reg_q     <= coef_reg_d;
            rd_q           <= rd_d;
            start_ready_q  <= start_ready_d;
            result_valid_q <= result_valid_d;
            result_q       <= result_d;
`ifdef HORNER_OVF_EN
            ovf_q          <= ovf_d;
`endif
        end
    end

    assign start_ready  = start_ready_q;
    assign result_valid = result_valid_q;
    assign result       = result_q;
`ifdef HORNER_OVF_EN
    assign ovf          = ovf_q;
`endif

endmodule

// File: doc/horner_sched.md
Name: horner_sched

Overview:
- Sequencing controller for the Horner polynomial evaluator.
- Takes one evaluation request (x, degree) and fetches coefficients from an external synchronous coefficient memory.
- Drives a pipelined WIDTH-bit multiplier and a 1-cycle adder through the multiply-accumulate recurrence `acc = acc*x + c[i]`, then returns the result over a valid/ready handshake.
- Replaces free-running coefficient-index stepping with explicit, latency-aware scheduling.

Parameters:
- WIDTH, 32: datapath width of x, coefficients and result.
- MAX_DEG, 15: highest supported polynomial degree.
- DEG_W, 4: width of degree and coefficient address; must satisfy 2^DEG_W >= MAX_DEG+1.
- MUL_LAT, 1: multiplier pipeline depth in cycles; must be >= 1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start_valid  in  1  request present
- start_ready  out  1  controller idle and able to accept a request
- x_in  in  WIDTH  evaluation point
- degree  in  DEG_W  polynomial degree N; c[N] is the leading coefficient
- coef_rd_en  out  1  coefficient memory read strobe
- coef_addr  out  DEG_W  coefficient index
- coef_data  in  WIDTH  read data, valid the cycle after coef_rd_en
- result_valid  out  1  result available
- result_ready  in  1  consumer accepts the result
- result  out  WIDTH  polynomial value mod 2^WIDTH
- ovf  out  1  overflow flag; only present when HORNER_OVF_EN is defined

Behaviour:
- Reset values:
  - start_ready = 1, result_valid = 0, result = 0, coef_rd_en = 0, coef_addr = 0, ovf = 0.
  - FSM state = IDLE, multiplier pipeline valid bits cleared.
- A rst asserted mid-evaluation aborts the evaluation. The controller is back in IDLE the next cycle; in-flight products are discarded.
- FSM states: IDLE, LOAD, MUL, MWAIT, ADD, DONE.
- IDLE:
  - start_ready = 1.
  - On start_valid & start_ready: latch x and N, set idx = N, pulse coef_rd_en with coef_addr = N, go to LOAD.
- LOAD:
  - acc <= coef_data.
  - If N == 0, go to DONE; otherwise go to MUL.
- MUL:
  - Issue acc and x to the multiplier.
  - Pulse coef_rd_en with coef_addr = idx-1; capture coef_data into coef_reg on the next cycle.
  - If MUL_LAT == 1, go to ADD; otherwise go to MWAIT.
- MWAIT:
  - Down-counter stays here for MUL_LAT-1 cycles, then goes to ADD.
- ADD:
  - acc <= prod[WIDTH-1:0] + coef_reg, truncated to WIDTH bits.
  - idx <= idx-1.
  - If idx-1 == 0, go to DONE; otherwise go to MUL.
- DONE:
  - result_valid = 1, result = acc; result stays stable while result_ready = 0.
  - On result_valid & result_ready: result_valid drops next cycle, go to IDLE. result keeps its last value.
- start_ready = 0 in every state except IDLE. start_valid is ignored while busy.
- Timing and throughput:
  - The accept cycle is cycle 0. result_valid first rises at cycle 2 + N*(MUL_LAT+1).
  - No back-to-back overlap: the next accept is earliest one cycle after result handshake completes.
- Arithmetic:
  - Unsigned.
  - Product upper WIDTH bits are dropped.
  - Adder carry-out is dropped.
- Degree handling: degree > MAX_DEG (possible only when 2^DEG_W > MAX_DEG+1) is clamped to MAX_DEG at accept.

Optional Feature:
- Macro: HORNER_OVF_EN.
- Defined:
  - The ovf port exists; it is cleared at accept.
  - ovf is set (sticky) when any ADD step sees a nonzero product upper half or an adder carry-out.
  - ovf is valid alongside result_valid.
- Undefined: no ovf port and no upper-half product logic; the multiplier produces only WIDTH bits.

Decomposition:
- Shared package horner_pkg:
  - FSM state enum.
  - WIDTH/DEG_W defaults.
  - Function computing the total latency 2 + N*(MUL_LAT+1), for bench reuse.
- One sub-module, horner_mul_pipe:
  - MUL_LAT-stage registered multiplier with a valid shift chain.
  - 2*WIDTH-bit product.
  - Synchronous clear on rst.

Test Plan:
- Memory c0..c3 = 1,2,3,4; x = 2; N = 3; MUL_LAT = 1 -> result = 49 (0x31), result_valid rises at cycle 8; exactly 4 coef reads at addresses 3,2,1,0.
- N = 0, c0 = 0x1234 -> result = 0x1234 at cycle 2; no multiplier issue.
- Same 49 case with result_ready held low 5 cycles -> result_valid and result stay stable, start_ready = 0, start_valid pulses are ignored; handshake completes, then start_ready = 1 next cycle.
- c1 = 0x10000, c0 = 5, x = 0x10000, N = 1 -> result = 5 (wrap); with HORNER_OVF_EN ovf = 1, and on a rerun with x = 2 ovf = 0.
- rst asserted in MWAIT (MUL_LAT = 3, N = 3) -> next cycle start_ready = 1, result_valid = 0, result = 0; a new request then evaluates correctly with latency 2 + 3*4 = 14.
- MUL_LAT = 3, same 1,2,3,4 / x = 2 case -> result = 49 at cycle 14.
